stump_control: RTL and testbench

- Stump sequencer. Drives the control inputs of the Stump ALU (function code, carry in) and consumes its NZVC flags output.
- Holds the condition-code register and evaluates branch conditions.
- Steps each instruction through FETCH, EXECUTE and, for loads/stores only, MEMORY.
- Sits between the instruction register, register bank, shifter, ALU and memory interface of the Stump datapath.

---
 rtl/stump_control_if.sv | 39 +++
 rtl/stump_control.sv | 193 +++++++++++++++++++
 tb/tb_stump_control.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stump_control_if.sv
// Stump sequencer <-> datapath control bundle.
// master: the sequencer (drives control, reads IR/flags/mem handshake).
// slave: the datapath side (register bank, shifter, ALU, memory interface).
interface stump_control_if;
  logic [15:0] ir;
  logic [3:0]  flags_in;
  logic        mem_ready;
  logic [1:0]  state;
  logic        ir_en;
  logic        pc_inc;
  logic [2:0]  alu_func;
  logic        c_in;
  logic [2:0]  src_a;
  logic [2:0]  src_b;
  logic [2:0]  dest;
  logic        reg_write;
  logic        opb_sel;
  logic        ext_op;
  logic [1:0]  shift_op;
  logic        mem_en;
  logic        mem_we;
  logic        addr_sel;
  logic [3:0]  cc;
  logic        branch_taken;

  modport master (
    input  ir, flags_in, mem_ready,
    output state, ir_en, pc_inc, alu_func, c_in, src_a, src_b, dest,
           reg_write, opb_sel, ext_op, shift_op, mem_en, mem_we, addr_sel,
           cc, branch_taken
  );

  modport slave (
    output ir, flags_in, mem_ready,
    input  state, ir_en, pc_inc, alu_func, c_in, src_a, src_b, dest,
           reg_write, opb_sel, ext_op, shift_op, mem_en, mem_we, addr_sel,
           cc, branch_taken
  );
endinterface

// File: rtl/stump_control.sv
// Stump sequencer: FETCH/EXECUTE/MEMORY stepping, NZVC condition-code register, branch evaluation.
// Latency: control outputs are combinational from state, IR and cc; state and cc update on each rising edge.
// Backpressure: mem_ready low holds FETCH or MEMORY (with all memory controls held) until it rises.
module stump_control #(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic            clk,
  input  logic            rst_n,
  stump_control_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    MEMORY  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  state_t     state_q, state_d;
  logic [3:0] cc_q, cc_d;

  // Instruction fields
  logic [2:0] op_f;
  logic       type_f;
  logic       s_f;
  logic [2:0] dst_f;
  logic [2:0] sa_f;
  logic [2:0] sb_f;
  logic [1:0] sh_f;
  logic [3:0] cond_f;

  assign op_f   = bus.ir[15:13];
  assign type_f = bus.ir[12];
  assign s_f    = bus.ir[11];
  assign dst_f  = bus.ir[10:8];
  assign sa_f   = bus.ir[7:5];
  assign sb_f   = bus.ir[4:2];
  assign sh_f   = bus.ir[1:0];
  assign cond_f = bus.ir[11:8];

  // Flag aliases from the registered condition codes
  logic flag_n, flag_z, flag_v, flag_c;
  assign flag_n = cc_q[3];
  assign flag_z = cc_q[2];
  assign flag_v = cc_q[1];
  assign flag_c = cc_q[0];

  // Combinational output shadows
  logic       ir_en_c, pc_inc_c, c_in_c, reg_write_c, opb_sel_c, ext_op_c;
  logic       mem_en_c, mem_we_c, addr_sel_c, branch_taken_c, cond_true;
  logic [2:0] alu_func_c, src_a_c, src_b_c, dest_c;
  logic [1:0] shift_op_c;

  // State and condition-code registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= state_t'(RESET_STATE);
      cc_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
    end
  end

  // Branch condition evaluated against the registered cc
  always_comb begin
    cond_true = 1'b0;
    case (cond_f)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = flag_c & ~flag_z;
      4'h3: cond_true = ~flag_c | flag_z;
      4'h4: cond_true = ~flag_c;
      4'h5: cond_true = flag_c;
      4'h6: cond_true = ~flag_z;
      4'h7: cond_true = flag_z;
      4'h8: cond_true = ~flag_v;
      4'h9: cond_true = flag_v;
      4'hA: cond_true = ~flag_n;
      4'hB: cond_true = flag_n;
      4'hC: cond_true = (flag_n == flag_v);
      4'hD: cond_true = (flag_n != flag_v);
      4'hE: cond_true = ~flag_z & (flag_n == flag_v);
      4'hF: cond_true = flag_z | (flag_n != flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state, cc update and per-state control decode
  always_comb begin
    state_d        = FETCH;
    cc_d           = cc_q;
    ir_en_c        = 1'b0;
    pc_inc_c       = 1'b0;
    alu_func_c     = 3'b000;
    c_in_c         = 1'b0;
    src_a_c        = 3'b000;
    src_b_c        = 3'b000;
    dest_c         = 3'b000;
    reg_write_c    = 1'b0;
    opb_sel_c      = 1'b0;
    ext_op_c       = 1'b0;
    shift_op_c     = 2'b00;
    mem_en_c       = 1'b0;
    mem_we_c       = 1'b0;
    addr_sel_c     = 1'b0;
    branch_taken_c = 1'b0;

    case (state_q)
      FETCH: begin
        c_in_c   = flag_c;
        mem_en_c = 1'b1;
        ir_en_c  = bus.mem_ready;
        pc_inc_c = bus.mem_ready;
        state_d  = bus.mem_ready ? EXECUTE : FETCH;
      end

      EXECUTE: begin
        c_in_c     = flag_c;
        alu_func_c = op_f;
        if (op_f == OP_BCC) begin
          // PC-relative branch: R7 + sign-extended offset8, written back only when taken
          src_a_c        = 3'd7;
          opb_sel_c      = 1'b1;
          ext_op_c       = 1'b1;
          dest_c         = 3'd7;
          branch_taken_c = cond_true;
          reg_write_c    = cond_true;
          state_d        = FETCH;
        end else begin
          src_a_c = sa_f;
          if (type_f) begin
            opb_sel_c = 1'b1;
          end else begin
            src_b_c    = sb_f;
            shift_op_c = sh_f;
          end
          if (op_f == OP_LDST) begin
            // Address computed here and registered for the MEMORY cycle
            state_d = MEMORY;
          end else begin
            dest_c      = dst_f;
            reg_write_c = 1'b1;
            if (s_f) begin
              cc_d = bus.flags_in;
            end
            state_d = FETCH;
          end
        end
      end

      MEMORY: begin
        c_in_c     = flag_c;
        mem_en_c   = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = s_f;
        src_a_c    = dst_f;
        if (!s_f) begin
          dest_c      = dst_f;
          reg_write_c = bus.mem_ready;
        end
        state_d = bus.mem_ready ? FETCH : MEMORY;
      end

      default: begin
        // Unreachable encoding: everything quiet, recover to FETCH
        state_d = FETCH;
      end
    endcase
  end

  assign bus.state        = state_q;
  assign bus.cc           = cc_q;
  assign bus.ir_en        = ir_en_c;
  assign bus.pc_inc       = pc_inc_c;
  assign bus.alu_func     = alu_func_c;
  assign bus.c_in         = c_in_c;
  assign bus.src_a        = src_a_c;
  assign bus.src_b        = src_b_c;
  assign bus.dest         = dest_c;
  assign bus.reg_write    = reg_write_c;
  assign bus.opb_sel      = opb_sel_c;
  assign bus.ext_op       = ext_op_c;
  assign bus.shift_op     = shift_op_c;
  assign bus.mem_en       = mem_en_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.addr_sel     = addr_sel_c;
  assign bus.branch_taken = branch_taken_c;

endmodule

// File: tb/tb_stump_control.sv
// Bench for the Stump sequencer: directed scenarios plus random instruction stream.
// Expected values come from a behavioural model of the instruction rules.
// Inputs are driven 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_stump_control;

  logic clk;
  logic rst_n;
  stump_control_if bus ();

  stump_control #(.RESET_STATE(2'b00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] state;
    logic       ir_en;
    logic       pc_inc;
    logic [2:0] alu_func;
    logic       c_in;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dest;
    logic       reg_write;
    logic       opb_sel;
    logic       ext_op;
    logic [1:0] shift_op;
    logic       mem_en;
    logic       mem_we;
    logic       addr_sel;
    logic [3:0] cc;
    logic       branch_taken;
  } outs_t;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = fetch, 1 = execute, 2 = memory
  int         m_state;
  logic [3:0] m_cc;

  // Branch rule: even codes pick a base condition, odd codes are its negation.
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] cc);
    logic n, z, v, c, base;
    n = cc[3]; z = cc[2]; v = cc[1]; c = cc[0];
    case (cond[3:1])
      3'd0: base = 1'b1;
      3'd1: base = c && !z;
      3'd2: base = !c;
      3'd3: base = !z;
      3'd4: base = !v;
      3'd5: base = !n;
      3'd6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ cond[0];
  endfunction

  function automatic outs_t model_out(input int st, input logic [15:0] ir,
                                      input logic [3:0] cc, input logic mr);
    outs_t o;
    logic [2:0] op;
    o = '0;
    op = ir[15:13];
    o.state = 2'(st);
    o.cc = cc;
    o.c_in = cc[0];
    if (st == 0) begin
      o.mem_en = 1'b1;
      o.ir_en = mr;
      o.pc_inc = mr;
    end else if (st == 1) begin
      o.alu_func = op;
      if (op == 3'd7) begin
        o.src_a = 3'd7; o.opb_sel = 1'b1; o.ext_op = 1'b1; o.dest = 3'd7;
        o.branch_taken = cond_ref(ir[11:8], cc);
        o.reg_write = o.branch_taken;
      end else begin
        o.src_a = ir[7:5];
        if (ir[12]) o.opb_sel = 1'b1;
        else begin o.src_b = ir[4:2]; o.shift_op = ir[1:0]; end
        if (op != 3'd6) begin o.dest = ir[10:8]; o.reg_write = 1'b1; end
      end
    end else begin
      o.mem_en = 1'b1; o.addr_sel = 1'b1; o.mem_we = ir[11]; o.src_a = ir[10:8];
      if (!ir[11]) begin o.dest = ir[10:8]; o.reg_write = mr; end
    end
    return o;
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.state = bus.state; o.ir_en = bus.ir_en; o.pc_inc = bus.pc_inc;
    o.alu_func = bus.alu_func; o.c_in = bus.c_in; o.src_a = bus.src_a;
    o.src_b = bus.src_b; o.dest = bus.dest; o.reg_write = bus.reg_write;
    o.opb_sel = bus.opb_sel; o.ext_op = bus.ext_op; o.shift_op = bus.shift_op;
    o.mem_en = bus.mem_en; o.mem_we = bus.mem_we; o.addr_sel = bus.addr_sel;
    o.cc = bus.cc; o.branch_taken = bus.branch_taken;
    return o;
  endfunction

  // One clock edge; model follows the instruction rules from the inputs seen at the edge.
  task automatic advance();
    int ns;
    logic [3:0] nc;
    ns = m_state; nc = m_cc;
    if (!rst_n) begin
      ns = 0; nc = 4'b0000;
    end else if (m_state == 0) begin
      if (bus.mem_ready) ns = 1;
    end else if (m_state == 1) begin
      ns = (bus.ir[15:13] == 3'd6) ? 2 : 0;
      if (bus.ir[15:13] < 3'd6 && bus.ir[11]) nc = bus.flags_in;
    end else begin
      if (bus.mem_ready) ns = 0;
    end
    @(posedge clk); #1;
    m_state = ns; m_cc = nc;
  endtask

  // From FETCH, complete the fetch and present the instruction in EXECUTE.
  task automatic fetch_into(input logic [15:0] ir);
    bus.mem_ready = 1'b1;
    advance();
    bus.ir = ir;
  endtask

  task automatic set_cc(input logic [3:0] v);
    fetch_into(16'h0800);
    bus.flags_in = v;
    advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.ir = 16'h0000; bus.flags_in = 4'h0;
    m_state = 3; m_cc = 4'hx;
    advance();
    advance();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b exp 00", bus.state); end
    n_checks++;
    if (bus.cc !== 4'b0000) begin n_errors++; $display("FAIL reset_cc: got %b exp 0000", bus.cc); end
    n_checks++;
    if (bus.mem_en !== 1'b1) begin n_errors++; $display("FAIL reset_mem_en: got %b exp 1", bus.mem_en); end
    advance();
    #1;
    n_checks++;
    if (bus.state !== 2'b01) begin n_errors++; $display("FAIL reset_to_exec: got %b exp 01", bus.state); end
    bus.ir = 16'h0044; bus.flags_in = 4'h0;
    advance();
  endtask

  task automatic test_flags();
    fetch_into(16'h0844);
    bus.flags_in = 4'b0101;
    #1;
    n_checks++;
    if (bus.reg_write !== 1'b1 || bus.dest !== 3'd0) begin
      n_errors++; $display("FAIL add_s_ctrl: got rw=%b dest=%0d exp rw=1 dest=0", bus.reg_write, bus.dest);
    end
    advance();
    #1;
    n_checks++;
    if (bus.cc !== 4'b0101) begin n_errors++; $display("FAIL add_s_cc: got %b exp 0101", bus.cc); end
    fetch_into(16'h0044);
    bus.flags_in = 4'b1010;
    advance();
    #1;
    n_checks++;
    if (bus.cc !== 4'b0101) begin n_errors++; $display("FAIL add_nos_cc: got %b exp 0101", bus.cc); end
  endtask

  task automatic test_branch();
    set_cc(4'b0100);
    fetch_into(16'hE705);
    #1;
    n_checks++;
    if (bus.branch_taken !== 1'b1 || bus.reg_write !== 1'b1 || bus.dest !== 3'd7 || bus.ext_op !== 1'b1) begin
      n_errors++;
      $display("FAIL beq_taken: got bt=%b rw=%b dest=%0d ext=%b exp 1 1 7 1",
               bus.branch_taken, bus.reg_write, bus.dest, bus.ext_op);
    end
    advance();
    fetch_into(16'hE605);
    #1;
    n_checks++;
    if (bus.reg_write !== 1'b0 || bus.branch_taken !== 1'b0) begin
      n_errors++; $display("FAIL bne_not_taken: got rw=%b bt=%b exp 0 0", bus.reg_write, bus.branch_taken);
    end
    advance();
  endtask

  task automatic test_load_stall();
    fetch_into(16'hC000);
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.state !== 2'b01 || bus.reg_write !== 1'b0) begin
      n_errors++; $display("FAIL ld_exec: got st=%b rw=%b exp 01 0", bus.state, bus.reg_write);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.state !== 2'b10 || bus.reg_write !== 1'b0 || bus.mem_en !== 1'b1 || bus.addr_sel !== 1'b1) begin
        n_errors++;
        $display("FAIL ld_stall%0d: got st=%b rw=%b en=%b as=%b exp 10 0 1 1",
                 i, bus.state, bus.reg_write, bus.mem_en, bus.addr_sel);
      end
      advance();
    end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.reg_write !== 1'b1 || bus.dest !== 3'd0) begin
      n_errors++; $display("FAIL ld_done: got rw=%b dest=%0d exp 1 0", bus.reg_write, bus.dest);
    end
    advance();
    #1;
    n_checks++;
    if (bus.state !== 2'b00) begin n_errors++; $display("FAIL ld_to_fetch: got %b exp 00", bus.state); end
  endtask

  task automatic test_store_reset();
    set_cc(4'b1011);
    fetch_into(16'hC800);
    bus.mem_ready = 1'b0;
    advance();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (bus.state !== 2'b10 || bus.mem_we !== 1'b1 || bus.reg_write !== 1'b0) begin
        n_errors++; $display("FAIL st_stall%0d: got st=%b we=%b rw=%b exp 10 1 0", i, bus.state, bus.mem_we, bus.reg_write);
      end
      advance();
    end
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.state !== 2'b00 || bus.cc !== 4'b0000 || bus.mem_we !== 1'b0) begin
      n_errors++; $display("FAIL st_reset: got st=%b cc=%b we=%b exp 00 0000 0", bus.state, bus.cc, bus.mem_we);
    end
  endtask

  task automatic test_cond_sweep();
    logic [3:0] ccs [4];
    outs_t got, exp;
    ccs[0] = 4'b0000; ccs[1] = 4'b1010; ccs[2] = 4'b1000; ccs[3] = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      set_cc(ccs[k]);
      for (int c = 0; c < 16; c++) begin
        fetch_into({4'hE, 4'(c), 8'h10});
        #1;
        got = observe();
        exp = model_out(m_state, bus.ir, m_cc, bus.mem_ready);
        n_checks++;
        if (got.branch_taken !== exp.branch_taken || got !== exp) begin
          n_errors++;
          $display("FAIL cond_%0h_cc%b: got bt=%b outs=%h exp bt=%b outs=%h",
                   c, ccs[k], got.branch_taken, got, exp.branch_taken, exp);
        end
        advance();
      end
    end
  endtask

  task automatic test_random();
    outs_t got, exp;
    for (int i = 0; i < 600; i++) begin
      if (m_state == 0) bus.ir = 16'($urandom);
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.flags_in = 4'($urandom);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      got = observe();
      exp = model_out(m_state, bus.ir, m_cc, bus.mem_ready);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL random_cyc%0d: got %h exp %h (ir=%h)", i, got, exp, bus.ir);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ir = 16'h0000;
    bus.flags_in = 4'h0;
    bus.mem_ready = 1'b0;
    m_state = 0;
    m_cc = 4'h0;
    test_reset();
    test_flags();
    test_branch();
    test_load_stall();
    test_store_reset();
    test_cond_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
